align_tx_32b: RTL and testbench
===============================

Name: align_tx_32b

Overview:
- TX-side 64b/66b gearbox for the 10GBASE-R path.
- Accepts 66-bit blocks as two 32-bit halves, with the 2-bit sync header supplied alongside the first (even) half.
- Packs the resulting bit stream into a continuous 32-bit word per clock for the transceiver.
- The rate mismatch of 33 output words per 16 blocks is absorbed by stalling the source one cycle in every 33.

Parameters:
- none (the 32-bit datapath and the 33-cycle period are fixed)

Ports:
- clk  input  1  transceiver TX parallel clock
- rst  input  1  asynchronous, active-high reset
- din  input  32  scrambled block half; first half = block bits [33:2], second half = block bits [65:34]
- ctrl  input  2  sync header (block bits [1:0]); sampled only on an accepted even half
- din_ready  output  1  half is accepted at the rising edge while high
- even  output  1  next accepted half is the first half of a block (header sampled)
- dout  output  32  packed word to the transceiver; dout[0] is transmitted first
- dout_en  output  1  dout holds valid stream data
- hdr_err  output  1  one-cycle pulse: ctrl was 00 or 11 on an accepted even half

Behaviour:
- Reset (async): cnt=0, run=0, residual=0, dout=0, dout_en=0, hdr_err=0. din_ready=0 and even=0 while rst is high or run=0.
- First clk edge after rst deasserts sets run=1. Nothing is accepted on that edge.
- Period counter cnt runs 0..32, then wraps to 0. It advances every edge while run=1.
- din_ready = run & (cnt!=32).
- even = run & (cnt!=32) & !cnt[0].
- Half index j = cnt (0..31); block b = j/2 within the period.
- Period-local stream layout, LSB first:
  - block b occupies bits 66b..66b+65
  - header at bits 66b+1:66b
  - first half at bits 66b+33:66b+2
  - second half at bits 66b+65:66b+34
- Word m (m=0..32) = stream bits 32m+31:32m.
- Word m is fully determined by all halves accepted up to and including the half at cnt=m. At m=32 only stored residual bits are used.
- On each edge with run=1 at cnt=m: dout <= word m; dout_en <= 1. Latency is one clock from acceptance of half m to dout = word m.
- Residual register holds the unsent stream bits after each word:
  - after word m (m<32) it holds 2*floor(m/2)+2 bits; maximum 32 bits after m=31
  - word 32 emits exactly those 32 bits
  - residual is 0 at every period boundary
- Stall: din is ignored at cnt=32, whatever the source drives. The source must hold its next half until din_ready returns.
- hdr_err:
  - registered, asserted the edge after an accepted even half with ctrl in {00,11}
  - ctrl is still transmitted unchanged
  - no effect on sequencing
- Reset mid-period: everything returns to reset values immediately. The partially packed block is discarded. The next period starts at cnt=0 with residual empty.
- No back-pressure from the output side. dout_en stays 1 continuously from the cycle after the first run edge until reset.

Test Plan:
- Reset: hold rst 5 cycles, check dout=0, dout_en=0, din_ready=0, even=0, hdr_err=0. Release; check din_ready rises 1 cycle later, with dout_en following 1 cycle after.
- All-zero data, ctrl=01 for every block → dout sequence per period:
  - word0=0x00000001, word1=0x00000000, word2=0x00000004, word4=0x00000010
  - word 2b = 1<<(2b) for b=0..15
  - all odd words and word32 = 0x00000000
  - pattern repeats every 33 words
- Stall: check din_ready=0 exactly 1 cycle in every 33 over 10 periods. Drive 0xDEADBEEF on the stall cycles and check it never appears in the stream.
- Random data and headers from {01,10} for 1000 blocks, with the source honouring din_ready. Reference serializer concatenates header/half0/half1 LSB-first; output stream must match it bit-exactly at 1-cycle latency.
- ctrl=00 on block 3 and ctrl=11 on block 7 → hdr_err pulses exactly twice, each 1 cycle after the corresponding even acceptance. Stream bits 198,199 = 00 and 462,463 = 11.
- Assert rst at cnt=17 for 1 cycle → outputs clear asynchronously. After restart, the first block lands at stream bit 0 (word0 = 0x00000001 with the stimulus of scenario 2).

Source files
------------

// File: rtl/align_tx_32b.sv
// -----------------------------------------------------------------------------
// align_tx_32b -- TX-side 64b/66b gearbox, 32-bit datapath (10GBASE-R)
//
// Takes 66-bit blocks as two 32-bit halves. The 2-bit sync header comes in
// alongside the first (even) half. The module packs the resulting LSB-first
// bit stream into one continuous 32-bit word per clock for the transceiver.
// Sixteen blocks (1056 bits) make exactly 33 output words. The source is
// therefore stalled for one cycle in every 33. On that cycle only stored
// residual bits are emitted.
//
// Ports
//   clk        in   1   transceiver TX parallel clock
//   rst        in   1   asynchronous, active-high reset
//   din        in  32   block half: first = block[33:2], second = block[65:34]
//   ctrl       in   2   sync header (block[1:0]); sampled on accepted even half
//   din_ready  out  1   a half is accepted at the rising edge while high
//   even       out  1   next accepted half is a block's first half
//   dout       out 32   packed word; dout[0] is transmitted first
//   dout_en    out  1   dout holds valid stream data
//   hdr_err    out  1   one-cycle pulse: ctrl was 00/11 on an accepted even half
// -----------------------------------------------------------------------------
module align_tx_32b (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic [1:0]  ctrl,
  output logic        din_ready,
  output logic        even,
  output logic [31:0] dout,
  output logic        dout_en,
  output logic        hdr_err
);

  // Sequencing: a single idle cycle after reset, then free-running forever.
  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'd32;

  state_t      state;
  state_t      state_nxt;
  logic        run;

  logic [5:0]  cnt;          // position within the 33-cycle period
  logic [5:0]  cnt_nxt;
  logic [31:0] residual;     // unsent stream bits, LSB = next to send
  logic [31:0] residual_nxt;
  logic [31:0] dout_nxt;
  logic        hdr_err_nxt;

  logic        stall;
  logic        accept;
  logic        accept_even;
  logic [5:0]  res_bits;     // number of valid bits held in residual
  logic [33:0] new_bits;     // bits contributed by the half accepted this edge
  logic [63:0] combined;     // residual followed by the new bits

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: the state register and every other flop use non-blocking (<=)
  // assignments, so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first. That way no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign run = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Source handshake
  // ---------------------------------------------------------------------------
  assign stall       = (cnt == LAST_CNT);
  assign accept      = run & ~stall;
  assign accept_even = accept & ~cnt[0];

  assign din_ready = accept;
  assign even      = accept_even;

  // ---------------------------------------------------------------------------
  // Packing datapath
  // ---------------------------------------------------------------------------
  // Before word m the residual holds m bits for even m and m+1 bits for odd m.
  // Each block adds 66 bits over two words, so 2 bits of slack build up per
  // block. That gives exactly 32 bits at cnt=32, which word 32 drains.
  always_comb begin
    res_bits     = cnt + {5'd0, cnt[0]};
    new_bits     = 34'd0;
    if (accept_even) begin
      new_bits = {din, ctrl};
    end else if (accept) begin
      new_bits = {2'b00, din};
    end
    // The new bits land just above the residual. The widest case is
    // 30 residual bits plus 34 new bits, or 32 plus 32, so 64 bits are
    // always enough and the shift never drops a set bit.
    combined     = {32'd0, residual} | ({30'd0, new_bits} << res_bits);
    dout_nxt     = combined[31:0];
    residual_nxt = combined[63:32];
    hdr_err_nxt  = accept_even & (ctrl[1] ~^ ctrl[0]);
    cnt_nxt      = stall ? 6'd0 : cnt + 6'd1;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the residual is reset together with the counter. A reset in the
  // middle of a period then discards the partial block, and the next period
  // starts with the first header at stream bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 6'd0;
      residual <= 32'd0;
      dout     <= 32'd0;
      dout_en  <= 1'b0;
      hdr_err  <= 1'b0;
    end else if (run) begin
      cnt      <= cnt_nxt;
      residual <= residual_nxt;
      dout     <= dout_nxt;
      dout_en  <= 1'b1;
      hdr_err  <= hdr_err_nxt;
    end else begin
      hdr_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_align_tx_32b.sv
// -----------------------------------------------------------------------------
// tb_align_tx_32b -- self-checking bench for align_tx_32b
//
// A reference serializer turns every half the model accepts into a bit queue,
// LSB first. On every run edge it pops 32 bits into a scoreboard of expected
// words. Each word is compared with dout one clock later. Hand-computed tables
// and short sequences cover reset, stalls, header errors and a restart after
// a reset in the middle of a period.
// -----------------------------------------------------------------------------
module tb_align_tx_32b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = 32'd0;
  logic [1:0]  ctrl = 2'b00;
  logic        din_ready;
  logic        even;
  logic [31:0] dout;
  logic        dout_en;
  logic        hdr_err;

  align_tx_32b dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .ctrl      (ctrl),
    .din_ready (din_ready),
    .even      (even),
    .dout      (dout),
    .dout_en   (dout_en),
    .hdr_err   (hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  c;
  } half_t;

  typedef struct {
    logic [1:0]  c;
    logic [31:0] h0;
    logic [31:0] h1;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  half_t       srcq[$];   // halves the source still has to send
  bit          bitq[$];   // reference serial stream
  logic [31:0] expq[$];   // scoreboard of expected words

  int checks = 0;
  int errors = 0;
  bit mrun   = 1'b0;
  int mcnt   = 0;
  int stall_seen = 0;
  int hdr_seen   = 0;
  int beef_seen  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_block(input logic [1:0] c, input logic [31:0] h0,
                            input logic [31:0] h1, input logic [1:0] c_odd);
    half_t h;
    h.d = h0; h.c = c;     srcq.push_back(h);
    h.d = h1; h.c = c_odd; srcq.push_back(h);
  endtask

  task automatic model_clear();
    bitq.delete();
    expq.delete();
    srcq.delete();
    mrun = 1'b0;
    mcnt = 0;
  endtask

  // Called at a falling edge with rst low. It drives one cycle of stimulus,
  // crosses one rising edge and returns at the next falling edge.
  task automatic cycle(output logic [31:0] got, output int m);
    half_t       h;
    logic        acc;
    logic        ev;
    logic        exp_hdr;
    logic        exp_en;
    logic [31:0] w;
    acc = mrun && (mcnt != 32);
    ev  = acc && (mcnt % 2 == 0);
    if (acc) begin
      if (srcq.size() > 0) begin
        h = srcq.pop_front();
      end else begin
        h.d = 32'd0;
        h.c = ev ? 2'b01 : 2'b00;
      end
    end else begin
      h.d = 32'hDEADBEEF;
      h.c = 2'b11;
    end
    din  = h.d;
    ctrl = h.c;
    #1;
    check("din_ready", din_ready, acc);
    check("even", even, ev);
    if (mrun && !din_ready) stall_seen++;
    if (acc) begin
      if (ev) begin
        bitq.push_back(h.c[0]);
        bitq.push_back(h.c[1]);
      end
      for (int i = 0; i < 32; i++) bitq.push_back(h.d[i]);
    end
    exp_hdr = ev && (h.c == 2'b00 || h.c == 2'b11);
    exp_en  = mrun;
    m       = mrun ? mcnt : -1;
    if (mrun) begin
      check("ref_underflow", {31'd0, bitq.size() < 32}, 32'd0);
      w = 32'd0;
      for (int i = 0; i < 32; i++) w[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      expq.push_back(w);
      mcnt = (mcnt == 32) ? 0 : mcnt + 1;
    end
    mrun = 1'b1;
    @(posedge clk);
    @(negedge clk);
    got = dout;
    check("dout_en", dout_en, exp_en);
    check("hdr_err", hdr_err, exp_hdr);
    if (hdr_err) hdr_seen++;
    if (dout_en && dout === 32'hDEADBEEF) beef_seen++;
    if (exp_en && expq.size() > 0) check("dout", dout, expq.pop_front());
  endtask

  // Asserts rst at the current time. It checks the asynchronous clear before
  // any clock edge, then holds rst for n cycles and releases it at a falling edge.
  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    check("rst_dout", dout, 32'd0);
    check("rst_dout_en", dout_en, 32'd0);
    check("rst_din_ready", din_ready, 32'd0);
    check("rst_even", even, 32'd0);
    check("rst_hdr_err", hdr_err, 32'd0);
    model_clear();
    repeat (n) @(negedge clk);
    check("rst_hold_din_ready", din_ready, 32'd0);
    check("rst_hold_dout_en", dout_en, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    vec_t        vt[5];
    logic [31:0] got;
    logic [31:0] w6;
    logic [31:0] w14;
    logic [1:0]  c;
    int          m;
    int          guard;

    // Single-block patterns: first two words of a period, computed by hand.
    vt[0] = '{c: 2'b01, h0: 32'h00000000, h1: 32'h00000000, w0: 32'h00000001, w1: 32'h00000000};
    vt[1] = '{c: 2'b10, h0: 32'hFFFFFFFF, h1: 32'h00000000, w0: 32'hFFFFFFFE, w1: 32'h00000003};
    vt[2] = '{c: 2'b01, h0: 32'h00000000, h1: 32'hFFFFFFFF, w0: 32'h00000001, w1: 32'hFFFFFFFC};
    vt[3] = '{c: 2'b10, h0: 32'h80000001, h1: 32'h00000001, w0: 32'h00000006, w1: 32'h00000006};
    vt[4] = '{c: 2'b01, h0: 32'h12345678, h1: 32'h9ABCDEF0, w0: 32'h48D159E1, w1: 32'h6AF37BC0};

    w6  = 32'd0;
    w14 = 32'd0;

    // Reset and release.
    @(negedge clk);
    do_reset(5);
    cycle(got, m);
    cycle(got, m);

    // Table of single-block patterns, each starting from a fresh reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      do_reset(2);
      cycle(got, m);
      push_block(vt[i].c, vt[i].h0, vt[i].h1, 2'b00);
      cycle(got, m);
      check($sformatf("tbl%0d_w0", i), got, vt[i].w0);
      cycle(got, m);
      check($sformatf("tbl%0d_w1", i), got, vt[i].w1);
    end

    // All-zero data with header 01 for 10 periods, with the stall cycles counted.
    @(negedge clk);
    do_reset(2);
    cycle(got, m);
    stall_seen = 0;
    beef_seen  = 0;
    for (int i = 0; i < 160; i++) push_block(2'b01, 32'd0, 32'd0, 2'b01);
    for (int k = 0; k < 330; k++) begin
      cycle(got, m);
      check("zero_word", got, (m % 2 == 0 && m < 32) ? (32'h1 << m) : 32'd0);
    end
    check("stall_count", stall_seen, 32'd10);
    check("beef_seen", beef_seen, 32'd0);

    // Header errors on blocks 3 and 7 of one period.
    check("period_start", mcnt, 32'd0);
    hdr_seen = 0;
    for (int b = 0; b < 16; b++) begin
      c = (b == 3) ? 2'b00 : (b == 7) ? 2'b11 : (($urandom & 1) != 0) ? 2'b01 : 2'b10;
      push_block(c, $urandom, $urandom, 2'b01);
    end
    for (int k = 0; k < 33; k++) begin
      cycle(got, m);
      if (m == 6)  w6  = got;
      if (m == 14) w14 = got;
    end
    check("hdr_pulses", hdr_seen, 32'd2);
    check("bits_198_199", {30'd0, w6[7:6]}, 32'd0);
    check("bits_462_463", {30'd0, w14[15:14]}, 32'd3);

    // Reset in the middle of a period, then restart from stream bit 0.
    for (int i = 0; i < 16; i++) push_block(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01);
    guard = 0;
    while (mcnt != 17 && guard < 40) begin
      cycle(got, m);
      guard++;
    end
    check("reach_cnt17", mcnt, 32'd17);
    do_reset(1);
    cycle(got, m);
    for (int i = 0; i < 16; i++) push_block(2'b01, 32'd0, 32'd0, 2'b01);
    cycle(got, m);
    check("restart_w0", got, 32'h00000001);
    cycle(got, m);
    check("restart_w1", got, 32'h00000000);
    cycle(got, m);
    check("restart_w2", got, 32'h00000004);

    // Random data with headers 01/10 for 1000 blocks. Odd-half ctrl is random.
    @(negedge clk);
    do_reset(2);
    cycle(got, m);
    for (int b = 0; b < 1000; b++) begin
      c = (($urandom & 1) != 0) ? 2'b01 : 2'b10;
      push_block(c, $urandom, $urandom, 2'($urandom_range(0, 3)));
    end
    guard = 0;
    while (srcq.size() > 0 && guard < 3000) begin
      cycle(got, m);
      guard++;
    end
    check("random_drained", srcq.size(), 32'd0);
    for (int k = 0; k < 35; k++) cycle(got, m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
